// File: rtl/counter_pkg.sv
// Shared definitions for counter_updown_mod: direction encoding, prescaler
// sizing and parameter legality predicates used at elaboration.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Prescaler counter width: ceil(log2(PRESCALE)), never below one bit.
    function automatic int unsigned prescale_width(input int unsigned prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

    function automatic bit width_ok(input int unsigned width);
        return (width >= 2) && (width <= 32);
    endfunction

    function automatic bit mod_ok(input longint unsigned mod_value, input int unsigned width);
        return (mod_value >= 2) && (mod_value <= (64'd1 << width));
    endfunction

    function automatic bit prescale_ok(input int unsigned prescale);
        return (prescale >= 1) && (prescale <= 65536);
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: tick is high on every PRESCALE-th enabled cycle. The phase
// holds while en is low and is cleared by sync_clr.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, sync_clr};
            assign tick          = en;
        end else begin : g_count
            localparam int unsigned PW = prescale_width(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] cnt_q, cnt_d;

            assign tick = en && (cnt_q == LAST);

            always_comb begin
                cnt_d = cnt_q;
                if (sync_clr) begin
                    cnt_d = '0;
                end else if (en) begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with prescaled enable, clamped parallel load and
// one-cycle wrap pulses. Define COUNTER_STICKY_EN to build the wrap_sticky flag.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 8,
    parameter longint unsigned MOD_VALUE = 64'd1 << WIDTH,
    parameter int unsigned     PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap_sticky
);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("counter_updown_mod: WIDTH must be 2..32");
        end
        if (!mod_ok(MOD_VALUE, WIDTH)) begin : g_bad_mod
            $error("counter_updown_mod: MOD_VALUE must be 2..2**WIDTH");
        end
        if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
            $error("counter_updown_mod: PRESCALE must be 1..65536");
        end
    endgenerate

    // With MOD_VALUE == 2**WIDTH this truncates to all-ones.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD_VALUE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             step;

    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync_clr(load),
        .tick    (step)
    );

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                if (count_q == MAX_VAL) begin
                    count_d = '0;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_VAL;
                    udf_d   = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign at_max    = (count_q == MAX_VAL);
    assign at_zero   = (count_q == '0);

`ifdef COUNTER_STICKY_EN
    logic sticky_q, sticky_d;

    // A wrap on the same edge as clear_flags keeps the flag set.
    always_comb begin
        sticky_d = sticky_q;
        if (ovf_d || udf_d) begin
            sticky_d = 1'b1;
        end else if (clear_flags) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign wrap_sticky = sticky_q;
`else
    logic unused_clear;
    assign unused_clear = clear_flags;
    assign wrap_sticky  = 1'b0;
`endif

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench for counter_updown_mod: three configurations share random and
// directed stimulus; expected outputs are queued per edge and checked by a monitor.
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic       clear_flags = 1'b0;
    logic [7:0] load_val = '0;

    logic [7:0] cnt_a;
    logic [3:0] cnt_b, cnt_c;
    logic [2:0] ovf, udf, amax, azero, stk;

    always #5 clk = ~clk;

    counter_updown_mod #(.WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clear_flags(clear_flags), .count(cnt_a),
        .overflow(ovf[0]), .underflow(udf[0]), .at_max(amax[0]),
        .at_zero(azero[0]), .wrap_sticky(stk[0])
    );

    counter_updown_mod #(.WIDTH(4), .MOD_VALUE(10), .PRESCALE(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[3:0]), .clear_flags(clear_flags), .count(cnt_b),
        .overflow(ovf[1]), .underflow(udf[1]), .at_max(amax[1]),
        .at_zero(azero[1]), .wrap_sticky(stk[1])
    );

    counter_updown_mod #(.WIDTH(4), .MOD_VALUE(16), .PRESCALE(4)) dut_c (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[3:0]), .clear_flags(clear_flags), .count(cnt_c),
        .overflow(ovf[2]), .underflow(udf[2]), .at_max(amax[2]),
        .at_zero(azero[2]), .wrap_sticky(stk[2])
    );

    // Reference model: integer modulo arithmetic over abstract state.
    int unsigned MODS [3] = '{256, 10, 16};
    int unsigned PRES [3] = '{1, 1, 4};
    int unsigned LVMOD[3] = '{256, 16, 16};

    int unsigned m_cnt[3];
    int unsigned m_ph [3];
    bit          m_ovf[3];
    bit          m_udf[3];
    bit          m_stk[3];

    typedef struct {
        int unsigned cnt;
        bit ovf, udf, amax, azero, stk;
    } exp_t;

    exp_t expq[3][$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_cnt(input int i);
        case (i)
            0:       return {24'd0, cnt_a};
            1:       return {28'd0, cnt_b};
            default: return {28'd0, cnt_c};
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_ph[i] = 0; m_ovf[i] = 0; m_udf[i] = 0; m_stk[i] = 0;
        end
    endfunction

    function automatic void model_edge(input int i, input bit e, input bit up, input bit ld,
                                       input int unsigned lv, input bit clr);
        int unsigned v;
        bit o, u;
        v = lv % LVMOD[i];
        o = 0; u = 0;
        if (ld) begin
            m_cnt[i] = (v >= MODS[i]) ? MODS[i] - 1 : v;
            m_ph[i]  = 0;
        end else if (e) begin
            if (m_ph[i] + 1 == PRES[i]) begin
                m_ph[i] = 0;
                if (up) begin
                    o = (m_cnt[i] + 1 == MODS[i]);
                    m_cnt[i] = (m_cnt[i] + 1) % MODS[i];
                end else begin
                    u = (m_cnt[i] == 0);
                    m_cnt[i] = (m_cnt[i] + MODS[i] - 1) % MODS[i];
                end
            end else begin
                m_ph[i] = m_ph[i] + 1;
            end
        end
        m_ovf[i] = o;
        m_udf[i] = u;
`ifdef COUNTER_STICKY_EN
        if (o || u) m_stk[i] = 1;
        else if (clr) m_stk[i] = 0;
`endif
    endfunction

    function automatic exp_t model_out(input int i);
        exp_t x;
        x.cnt   = m_cnt[i];
        x.ovf   = m_ovf[i];
        x.udf   = m_udf[i];
        x.amax  = (m_cnt[i] == MODS[i] - 1);
        x.azero = (m_cnt[i] == 0);
        x.stk   = m_stk[i];
        return x;
    endfunction

    // Drive one cycle's inputs at the falling edge and queue the post-edge expectation.
    task automatic cycle(input bit r, input bit e, input bit up, input bit ld,
                         input logic [7:0] lv, input bit clr);
        @(negedge clk);
        rst = r; en = e; up_dn = up; load = ld; load_val = lv; clear_flags = clr;
        for (int i = 0; i < 3; i++) begin
            if (r) model_reset();
            else model_edge(i, e, up, ld, int'(lv), clr);
            expq[i].push_back(model_out(i));
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every rising edge, compare DUT outputs against queued expectations.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (expq[i].size() > 0) begin
                exp_t x;
                x = expq[i].pop_front();
                chk($sformatf("dut%0d.count", i), dut_cnt(i), x.cnt);
                chk($sformatf("dut%0d.overflow", i), 32'(ovf[i]), 32'(x.ovf));
                chk($sformatf("dut%0d.underflow", i), 32'(udf[i]), 32'(x.udf));
                chk($sformatf("dut%0d.at_max", i), 32'(amax[i]), 32'(x.amax));
                chk($sformatf("dut%0d.at_zero", i), 32'(azero[i]), 32'(x.azero));
                chk($sformatf("dut%0d.wrap_sticky", i), 32'(stk[i]), 32'(x.stk));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) cycle(1, 0, 1, 0, 8'h00, 0);

        // Asynchronous reset mid-cycle from a loaded value.
        cycle(0, 0, 1, 1, 8'h37, 0);
        @(posedge clk);
        #2;
        chk("preload_a", {24'd0, cnt_a}, 32'h37);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_count", {24'd0, cnt_a}, 32'd0);
        chk("async_rst_zero", 32'(azero[0]), 32'd1);
        chk("async_rst_max", 32'(amax[0]), 32'd0);
        chk("async_rst_flags", 32'({ovf, udf, stk}), 32'd0);
        cycle(1, 0, 1, 0, 8'h00, 0);
        repeat (10) cycle(0, 0, 1, 0, 8'h00, 0);
        chk("hold_after_rst", {24'd0, cnt_a}, 32'd0);

        // Up-count wrap on the default 8-bit configuration.
        cycle(0, 0, 1, 1, 8'hFE, 0);
        cycle(0, 1, 1, 0, 8'h00, 0);
        settle(); chk("up_ff", {24'd0, cnt_a}, 32'hFF);
        cycle(0, 1, 1, 0, 8'h00, 0);
        settle(); chk("up_wrap", {24'd0, cnt_a}, 32'h00); chk("up_wrap_ovf", 32'(ovf[0]), 32'd1);
        cycle(0, 1, 1, 0, 8'h00, 0);
        settle(); chk("up_01", {24'd0, cnt_a}, 32'h01); chk("up_01_ovf", 32'(ovf[0]), 32'd0);

        // MOD_VALUE=10 down-count wrap.
        cycle(0, 0, 0, 1, 8'h02, 0);
        cycle(0, 1, 0, 0, 8'h00, 0);
        settle(); chk("dn_1", {28'd0, cnt_b}, 32'd1);
        cycle(0, 1, 0, 0, 8'h00, 0);
        settle(); chk("dn_0", {28'd0, cnt_b}, 32'd0); chk("dn_0_zero", 32'(azero[1]), 32'd1);
        chk("dn_0_udf", 32'(udf[1]), 32'd0);
        cycle(0, 1, 0, 0, 8'h00, 0);
        settle(); chk("dn_9", {28'd0, cnt_b}, 32'd9); chk("dn_9_udf", 32'(udf[1]), 32'd1);

        // Prescale=4: continuous, paused mid-phase, and phase cleared by load.
        cycle(0, 0, 1, 1, 8'h00, 0);
        repeat (12) cycle(0, 1, 1, 0, 8'h00, 0);
        settle(); chk("ps_three_steps", {28'd0, cnt_c}, 32'd3);
        repeat (2) cycle(0, 1, 1, 0, 8'h00, 0);
        repeat (3) cycle(0, 0, 1, 0, 8'h00, 0);
        repeat (2) cycle(0, 1, 1, 0, 8'h00, 0);
        settle(); chk("ps_paused_step", {28'd0, cnt_c}, 32'd4);
        repeat (2) cycle(0, 1, 1, 0, 8'h00, 0);
        cycle(0, 1, 1, 1, 8'h05, 0);
        repeat (3) cycle(0, 1, 1, 0, 8'h00, 0);
        settle(); chk("ps_load_phase", {28'd0, cnt_c}, 32'd5);
        cycle(0, 1, 1, 0, 8'h00, 0);
        settle(); chk("ps_load_step", {28'd0, cnt_c}, 32'd6);

        // Load wins over a step and clamps above the terminal value.
        cycle(0, 1, 1, 1, 8'h0F, 0);
        settle(); chk("clamp", {28'd0, cnt_b}, 32'd9); chk("clamp_noflag", 32'({ovf[1], udf[1]}), 32'd0);

        // Sticky behaviour (expected 0 throughout when the feature is compiled out).
        cycle(0, 1, 1, 0, 8'h00, 0);
        repeat (5) cycle(0, 0, 1, 0, 8'h00, 0);
`ifdef COUNTER_STICKY_EN
        settle(); chk("sticky_held", 32'(stk[1]), 32'd1);
`else
        settle(); chk("sticky_off", 32'(stk[1]), 32'd0);
`endif
        cycle(0, 0, 1, 0, 8'h00, 1);
        cycle(0, 0, 1, 1, 8'h09, 0);
        cycle(0, 1, 1, 0, 8'h00, 1);
        repeat (2) cycle(0, 0, 1, 0, 8'h00, 0);

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom()),
                  ($urandom_range(0, 19) == 0),
                  8'($urandom()),
                  ($urandom_range(0, 9) == 0));
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("queue%0d_drained", i), expq[i].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
